// File: rtl/load_store_unit.sv
// load_store_unit: bridges one byte-addressed load/store request onto a
// word-addressed synchronous data memory. Handles byte-lane extraction with
// sign/zero extension, read-modify-write for sub-word stores off lane 0, and
// a one-cycle response pulse.
//
// Ports:
//   Clk, Reset                - clock, asynchronous active-low reset
//   req_valid/req_ready       - request handshake (ready only in IDLE)
//   req_op/req_addr/req_wdata - operation, byte address, store data
//   resp_valid/rdata/err      - response pulse, load data or SC status, error flag
//   mem_ad/mem_wrdata/mem_wr  - memory word address, write data, write strobe code
//   mem_cut_sel               - memory lane select, tied to full word
//   mem_rdata                 - memory read data (one cycle after mem_ad)
//
// Optional feature: define LSU_LLSC_EN to enable LL/SC with a one-entry
// reservation. Without it, ops 12 and 13 are illegal.
module load_store_unit #(
    parameter int unsigned ADDR_W = 6
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_op,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_ad,
    output logic [31:0]       mem_wrdata,
    output logic [2:0]        mem_wr,
    output logic [1:0]        mem_cut_sel,
    input  logic [31:0]       mem_rdata
);

    localparam logic [3:0] OP_LW  = 4'd0;
    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_SW  = 4'd8;
    localparam logic [3:0] OP_SB  = 4'd9;
    localparam logic [3:0] OP_SH  = 4'd10;
`ifdef LSU_LLSC_EN
    localparam logic [3:0] OP_LL  = 4'd12;
    localparam logic [3:0] OP_SC  = 4'd13;
`endif

    localparam logic [2:0] WR_WORD = 3'd1;
    localparam logic [2:0] WR_BYTE = 3'd2;
    localparam logic [2:0] WR_HALF = 3'd4;

    typedef enum logic [2:0] {IDLE, RD, WAIT, WR, RESP} state_t;

    state_t      state;
    logic [3:0]  op_q;
    logic [1:0]  lane_q;
    logic [31:0] wdata_q;
    logic        rmw_q;

    logic        legal_c, load_c, store_c, need_word_c, need_half_c, err_c, rmw_c;
    logic [2:0]  wr_code_c;
    logic [7:0]  byte_c;
    logic [15:0] half_c;
    logic [31:0] load_val_c, merge_val_c;

`ifdef LSU_LLSC_EN
    logic              sc_c;
    logic              sc_ok_c;
    logic              resv_valid;
    logic [ADDR_W-1:0] resv_word;

    assign sc_ok_c = resv_valid && (resv_word == req_addr[ADDR_W+1:2]);
`endif

    assign mem_cut_sel = 2'b00;

    // Request decode and accept-time error check
    always_comb begin
        legal_c     = 1'b0;
        load_c      = 1'b0;
        store_c     = 1'b0;
        need_word_c = 1'b0;
        need_half_c = 1'b0;
        wr_code_c   = WR_WORD;
`ifdef LSU_LLSC_EN
        sc_c        = 1'b0;
`endif
        case (req_op)
            OP_LW:         begin legal_c = 1'b1; load_c = 1'b1; need_word_c = 1'b1; end
            OP_LB, OP_LBU: begin legal_c = 1'b1; load_c = 1'b1; end
            OP_LH, OP_LHU: begin legal_c = 1'b1; load_c = 1'b1; need_half_c = 1'b1; end
            OP_SW:         begin legal_c = 1'b1; store_c = 1'b1; need_word_c = 1'b1; end
            OP_SB:         begin legal_c = 1'b1; store_c = 1'b1; wr_code_c = WR_BYTE; end
            OP_SH: begin
                legal_c = 1'b1; store_c = 1'b1; need_half_c = 1'b1; wr_code_c = WR_HALF;
            end
`ifdef LSU_LLSC_EN
            OP_LL:         begin legal_c = 1'b1; load_c = 1'b1; need_word_c = 1'b1; end
            OP_SC:         begin legal_c = 1'b1; sc_c = 1'b1; need_word_c = 1'b1; end
`endif
            default: ;
        endcase
        err_c = !legal_c
              || (need_word_c && (req_addr[1:0] != 2'b00))
              || (need_half_c && req_addr[0])
              || (req_addr[31:ADDR_W+2] != '0);
        // Only SB/SH can reach here off lane 0; those need read-modify-write
        rmw_c = store_c && (req_addr[1:0] != 2'b00);
    end

    // Lane extraction for loads and lane merge for sub-word stores
    always_comb begin
        byte_c = mem_rdata[{lane_q, 3'b000} +: 8];
        half_c = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (op_q)
            OP_LB:   load_val_c = {{24{byte_c[7]}}, byte_c};
            OP_LBU:  load_val_c = {24'd0, byte_c};
            OP_LH:   load_val_c = {{16{half_c[15]}}, half_c};
            OP_LHU:  load_val_c = {16'd0, half_c};
            default: load_val_c = mem_rdata;
        endcase
        merge_val_c = mem_rdata;
        if (op_q == OP_SH) begin
            if (lane_q[1]) merge_val_c[31:16] = wdata_q[15:0];
            else           merge_val_c[15:0]  = wdata_q[15:0];
        end else begin
            merge_val_c[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
        end
    end

    // Control FSM with registered outputs
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
            mem_ad     <= '0;
            mem_wrdata <= 32'd0;
            mem_wr     <= 3'd0;
            op_q       <= 4'd0;
            lane_q     <= 2'd0;
            wdata_q    <= 32'd0;
            rmw_q      <= 1'b0;
`ifdef LSU_LLSC_EN
            resv_valid <= 1'b0;
            resv_word  <= '0;
`endif
        end else begin
            resp_valid <= 1'b0;
            mem_wr     <= 3'd0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready  <= 1'b0;
                        op_q       <= req_op;
                        lane_q     <= req_addr[1:0];
                        wdata_q    <= req_wdata;
                        rmw_q      <= rmw_c;
                        mem_ad     <= req_addr[ADDR_W+1:2];
                        resp_rdata <= 32'd0;
                        resp_err   <= 1'b0;
                        if (err_c) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                        end else if (load_c || rmw_c) begin
                            state <= RD;
`ifdef LSU_LLSC_EN
                        end else if (sc_c) begin
                            // SC outcome is fixed here; a failed SC passes WR without writing
                            state      <= WR;
                            resv_valid <= 1'b0;
                            mem_wrdata <= req_wdata;
                            if (sc_ok_c) begin
                                mem_wr     <= WR_WORD;
                                resp_rdata <= 32'd1;
                            end
`endif
                        end else begin
                            state      <= WR;
                            mem_wr     <= wr_code_c;
                            mem_wrdata <= req_wdata;
                        end
                    end
                end
                RD: state <= WAIT;
                WAIT: begin
                    if (rmw_q) begin
                        state      <= WR;
                        mem_wr     <= WR_WORD;
                        mem_wrdata <= merge_val_c;
                    end else begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= load_val_c;
`ifdef LSU_LLSC_EN
                        if (op_q == OP_LL) begin
                            resv_valid <= 1'b1;
                            resv_word  <= mem_ad;
                        end
`endif
                    end
                end
                WR: begin
                    state      <= RESP;
                    resp_valid <= 1'b1;
`ifdef LSU_LLSC_EN
                    if ((mem_wr != 3'd0) && (mem_ad == resv_word)) resv_valid <= 1'b0;
`endif
                end
                RESP: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: table-driven check of load_store_unit against a
// synchronous word memory model; expectations come from a scoreboard queue.
module tb_load_store_unit;

    localparam int unsigned ADDR_W = 6;

    logic              Clk = 1'b0;
    logic              Reset = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [3:0]        req_op = 4'd0;
    logic [31:0]       req_addr = 32'd0;
    logic [31:0]       req_wdata = 32'd0;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic [ADDR_W-1:0] mem_ad;
    logic [31:0]       mem_wrdata;
    logic [2:0]        mem_wr;
    logic [1:0]        mem_cut_sel;
    logic [31:0]       mem_rdata = 32'd0;
    logic              init_mem = 1'b1;
    logic [31:0]       mem [64];

    load_store_unit #(.ADDR_W(ADDR_W)) dut (
        .Clk(Clk), .Reset(Reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_ad(mem_ad), .mem_wrdata(mem_wrdata), .mem_wr(mem_wr),
        .mem_cut_sel(mem_cut_sel), .mem_rdata(mem_rdata)
    );

    always #5 Clk = ~Clk;

    // Synchronous-read word memory with byte/half/word write codes
    always @(posedge Clk) begin
        if (init_mem) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h1000_0000 + 32'(i);
            mem[5] <= 32'h8081_82F3;
        end else begin
            mem_rdata <= mem[mem_ad];
            case (mem_wr)
                3'd1: mem[mem_ad]       <= mem_wrdata;
                3'd2: mem[mem_ad][7:0]  <= mem_wrdata[7:0];
                3'd4: mem[mem_ad][15:0] <= mem_wrdata[15:0];
                default: ;
            endcase
        end
    end

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        logic [2:0]  exp_wr;
        int          exp_wcyc;
        logic [31:0] exp_wdat;
        logic [31:0] exp_wmask;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   checks = 0;
    int   fails = 0;

    function automatic vec_t ld(input logic [3:0] op, input logic [31:0] addr,
                                input logic [31:0] rd);
        vec_t v = '{op, addr, 32'd0, rd, 1'b0, 3, 3'd0, 0, 32'd0, 32'd0};
        return v;
    endfunction

    function automatic vec_t er(input logic [3:0] op, input logic [31:0] addr);
        vec_t v = '{op, addr, 32'd0, 32'd0, 1'b1, 1, 3'd0, 0, 32'd0, 32'd0};
        return v;
    endfunction

    function automatic vec_t st(input logic [3:0] op, input logic [31:0] addr,
                                input logic [31:0] wd, input logic [31:0] rd, input int lat,
                                input logic [2:0] wr, input int wcyc,
                                input logic [31:0] wdat, input logic [31:0] wmask);
        vec_t v = '{op, addr, wd, rd, 1'b0, lat, wr, wcyc, wdat, wmask};
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Drive one request; pop its expectation when the response shows up
    task automatic run_req(input string tag, input vec_t v);
        vec_t        e;
        int          got_lat = 0;
        int          got_wcyc = 0;
        logic [2:0]  got_wr = 3'd0;
        logic [31:0] got_wdat = 32'd0;
        logic [31:0] got_rdata = 32'd0;
        logic        got_err = 1'b0;
        sb.push_back(v);
        @(negedge Clk);
        chk({tag, "_ready_idle"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_op = v.op; req_addr = v.addr; req_wdata = v.wdata;
        @(posedge Clk);
        #1;
        req_valid = 1'b0;
        req_op    = 4'($urandom());
        req_addr  = $urandom();
        req_wdata = $urandom();
        for (int cyc = 1; cyc <= 8 && got_lat == 0; cyc++) begin
            @(negedge Clk);
            if (cyc == 1) chk({tag, "_ready_busy"}, 32'(req_ready), 32'd0);
            if (mem_wr != 3'd0) begin
                got_wr = mem_wr; got_wcyc = cyc; got_wdat = mem_wrdata;
            end
            if (resp_valid) begin
                got_lat = cyc; got_rdata = resp_rdata; got_err = resp_err;
            end
        end
        e = sb.pop_front();
        if (got_lat == 0) begin
            checks++; fails++;
            $display("FAIL %s_timeout: no resp_valid within 8 cycles, expected at %0d",
                     tag, e.exp_lat);
            return;
        end
        chk({tag, "_lat"}, 32'(got_lat), 32'(e.exp_lat));
        chk({tag, "_rdata"}, got_rdata, e.exp_rdata);
        chk({tag, "_err"}, 32'(got_err), 32'(e.exp_err));
        chk({tag, "_memwr"}, 32'(got_wr), 32'(e.exp_wr));
        if (e.exp_wr != 3'd0) begin
            chk({tag, "_wcyc"}, 32'(got_wcyc), 32'(e.exp_wcyc));
            chk({tag, "_wdat"}, got_wdat & e.exp_wmask, e.exp_wdat & e.exp_wmask);
        end
    endtask

    task automatic pulse_reset();
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        Reset = 1'b1;
    endtask

    initial begin
        // Word 5 = 8081_82F3, word n = 1000_00nn elsewhere
        vecs.push_back(ld(4'd1, 32'h14, 32'hFFFF_FFF3));
        vecs.push_back(ld(4'd2, 32'h15, 32'h0000_0082));
        vecs.push_back(ld(4'd3, 32'h16, 32'hFFFF_8081));
        vecs.push_back(er(4'd0, 32'h16));
        vecs.push_back(st(4'd9, 32'h17, 32'h0000_00AB, 0, 4, 3'd1, 3, 32'hAB81_82F3, '1));
        vecs.push_back(ld(4'd0, 32'h14, 32'hAB81_82F3));
        vecs.push_back(st(4'd10, 32'h14, 32'h0000_1234, 0, 2, 3'd4, 1, 32'h0000_1234,
                          32'h0000_FFFF));
        vecs.push_back(ld(4'd0, 32'h14, 32'hAB81_1234));
        vecs.push_back(er(4'd0, 32'h100));
        vecs.push_back(er(4'd3, 32'h15));
        vecs.push_back(er(4'd5, 32'h14));
        vecs.push_back(er(4'd8, 32'h21));
        vecs.push_back(st(4'd8, 32'h20, 32'hDEAD_BEEF, 0, 2, 3'd1, 1, 32'hDEAD_BEEF, '1));
        vecs.push_back(ld(4'd0, 32'h20, 32'hDEAD_BEEF));
        vecs.push_back(st(4'd10, 32'h22, 32'hFFFF_CAFE, 0, 4, 3'd1, 3, 32'hCAFE_BEEF, '1));
        vecs.push_back(ld(4'd3, 32'h22, 32'hFFFF_CAFE));
        vecs.push_back(st(4'd9, 32'h20, 32'h1234_5677, 0, 2, 3'd2, 1, 32'h0000_0077,
                          32'h0000_00FF));
        vecs.push_back(ld(4'd0, 32'h20, 32'hCAFE_BE77));
        vecs.push_back(ld(4'd2, 32'h23, 32'h0000_00CA));
        vecs.push_back(ld(4'd1, 32'h21, 32'hFFFF_FFBE));
        vecs.push_back(ld(4'd4, 32'h22, 32'h0000_CAFE));
        vecs.push_back(ld(4'd0, 32'hFC, 32'h1000_003F));
        vecs.push_back(st(4'd9, 32'h13, 32'h0000_005A, 0, 4, 3'd1, 3, 32'h5A00_0004, '1));
        vecs.push_back(ld(4'd1, 32'h13, 32'h0000_005A));
        vecs.push_back(ld(4'd2, 32'h16, 32'h0000_0081));
        vecs.push_back(ld(4'd1, 32'h16, 32'hFFFF_FF81));
`ifdef LSU_LLSC_EN
        vecs.push_back(ld(4'd12, 32'h20, 32'hCAFE_BE77));
        vecs.push_back(st(4'd13, 32'h20, 32'h600D_F00D, 1, 2, 3'd1, 1, 32'h600D_F00D, '1));
        vecs.push_back(st(4'd13, 32'h20, 32'h0000_0BAD, 0, 2, 3'd0, 0, 32'd0, 32'd0));
        vecs.push_back(ld(4'd0, 32'h20, 32'h600D_F00D));
        vecs.push_back(ld(4'd12, 32'h20, 32'h600D_F00D));
        vecs.push_back(st(4'd8, 32'h20, 32'h1111_1111, 0, 2, 3'd1, 1, 32'h1111_1111, '1));
        vecs.push_back(st(4'd13, 32'h20, 32'h2222_2222, 0, 2, 3'd0, 0, 32'd0, 32'd0));
        vecs.push_back(ld(4'd0, 32'h20, 32'h1111_1111));
        vecs.push_back(er(4'd13, 32'h22));
`else
        vecs.push_back(er(4'd12, 32'h20));
        vecs.push_back(er(4'd13, 32'h20));
`endif

        // Reset state
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        init_mem = 1'b0;
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_memwr", 32'(mem_wr), 32'd0);
        chk("rst_mem_ad", 32'(mem_ad), 32'd0);
        chk("rst_cut_sel", 32'(mem_cut_sel), 32'd0);
        Reset = 1'b1;

        foreach (vecs[i]) run_req($sformatf("v%0d", i), vecs[i]);

        // Reset dropped while a store sits in WR: write must be suppressed
        @(negedge Clk);
        req_valid = 1'b1; req_op = 4'd8; req_addr = 32'h30; req_wdata = 32'h1122_3344;
        @(posedge Clk);
        #1;
        req_valid = 1'b0;
        chk("wr_before_rst", 32'(mem_wr), 32'd1);
        #1 Reset = 1'b0;
        #1 chk("memwr_async_clear", 32'(mem_wr), 32'd0);
        @(negedge Clk);
        chk("rst_no_resp", 32'(resp_valid), 32'd0);
        chk("rst_wrdata", mem_wrdata, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_err", 32'(resp_err), 32'd0);
        Reset = 1'b1;
        @(negedge Clk);
        chk("post_rst_no_resp", 32'(resp_valid), 32'd0);
        chk("post_rst_ready", 32'(req_ready), 32'd1);
        run_req("after_rst_lw", ld(4'd0, 32'h30, 32'h1000_000C));

`ifdef LSU_LLSC_EN
        // Reset clears the reservation
        run_req("ll_pre_rst", ld(4'd12, 32'h20, 32'h1111_1111));
        pulse_reset();
        run_req("sc_post_rst", st(4'd13, 32'h20, 32'h3333_3333, 0, 2, 3'd0, 0, 32'd0, 32'd0));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
